// File: rtl/light_mode_controller.sv
// Button-stepped colour selector with white, static, blink and linear-fade output modes.
// All outputs are registered; the colour target is a lookup from the current index.
module light_mode_controller #(
  parameter int unsigned CH_W      = 8,
  parameter int unsigned BLINK_CYC = 16,
  parameter int unsigned FADE_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              button,
  output logic [3*CH_W-1:0] light,
  output logic [2:0]        colour_idx,
  output logic              busy
);

  localparam int unsigned LIGHT_W = 3 * CH_W;
  localparam int unsigned CNT_W   = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [CH_W-1:0]  CH_MAX   = '1;
  localparam logic [CH_W-1:0]  CH_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);
  localparam logic [CH_W:0]    STEP     = (CH_W + 1)'(FADE_STEP);
  localparam logic [2:0]       IDX_LAST = 3'd5;

  localparam logic [1:0] MODE_WHITE  = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_FADE   = 2'd3;

  logic               button_q;
  logic [CNT_W-1:0]   blink_cnt;
  logic               blink_on;

  logic [LIGHT_W-1:0] target;
  logic [LIGHT_W-1:0] light_n;
  logic [2:0]         colour_idx_n;
  logic               busy_n;
  logic [CNT_W-1:0]   blink_cnt_n;
  logic               blink_on_n;

  // One fade step for a single channel; widened by one bit so the sums cannot wrap.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] cur,
                                               input logic [CH_W-1:0] tgt);
    logic [CH_W:0] c;
    logic [CH_W:0] t;
    logic [CH_W:0] res;
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    res = c;
    if (c < t) begin
      res = ((c + STEP) > t) ? t : (c + STEP);
    end else if (c > t) begin
      res = (c < (t + STEP)) ? t : (c - STEP);
    end
    return CH_W'(res);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      light      <= '0;
      colour_idx <= 3'd0;
      busy       <= 1'b0;
      button_q   <= 1'b0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
    end else begin
      light      <= light_n;
      colour_idx <= colour_idx_n;
      busy       <= busy_n;
      button_q   <= button;
      blink_cnt  <= blink_cnt_n;
      blink_on   <= blink_on_n;
    end
  end

  // Colour index to {R,G,B} target
  always_comb begin
    target = '0;
    case (colour_idx)
      3'd0:    target = {CH_MAX,  CH_ZERO, CH_ZERO};
      3'd1:    target = {CH_MAX,  CH_MAX,  CH_ZERO};
      3'd2:    target = {CH_ZERO, CH_MAX,  CH_ZERO};
      3'd3:    target = {CH_ZERO, CH_MAX,  CH_MAX};
      3'd4:    target = {CH_ZERO, CH_ZERO, CH_MAX};
      3'd5:    target = {CH_MAX,  CH_ZERO, CH_MAX};
      default: target = '0;
    endcase
  end

  // Next-state: index stepping, blink timing, per-mode light and busy
  always_comb begin
    colour_idx_n = colour_idx;
    blink_cnt_n  = '0;
    blink_on_n   = 1'b1;
    light_n      = light;
    busy_n       = 1'b0;

    if (button && !button_q) begin
      colour_idx_n = (colour_idx == IDX_LAST) ? 3'd0 : colour_idx + 3'd1;
    end

    if (mode == MODE_BLINK) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt_n = '0;
        blink_on_n  = ~blink_on;
      end else begin
        blink_cnt_n = blink_cnt + CNT_W'(1);
        blink_on_n  = blink_on;
      end
    end

    case (mode)
      MODE_WHITE:  light_n = '1;
      MODE_STATIC: light_n = target;
      MODE_BLINK:  light_n = blink_on ? target : '0;
      MODE_FADE: begin
        for (int c = 0; c < 3; c++) begin
          light_n[c*CH_W +: CH_W] = fade_ch(light[c*CH_W +: CH_W], target[c*CH_W +: CH_W]);
        end
      end
      default:     light_n = light;
    endcase

    busy_n = (mode == MODE_FADE) && (light_n != target);
  end

endmodule

// File: tb/tb_light_mode_controller.sv
// Directed bench for light_mode_controller: a behavioural model feeds a per-cycle scoreboard,
// and directed constant checks pin the headline behaviours of each scenario.
module tb_light_mode_controller;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        button;
  logic [23:0] light_a;
  logic [23:0] light_b;
  logic [2:0]  idx_a;
  logic [2:0]  idx_b;
  logic        busy_a;
  logic        busy_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] la;
    logic [23:0] lb;
    logic [2:0]  idx;
    logic        ba;
    logic        bb;
  } exp_t;

  exp_t sb[$];

  // Reference model state (slow fade = step 1, fast fade = step 16)
  int m_la[3];
  int m_lb[3];
  int m_idx;
  int m_bq;
  int m_cnt;
  int m_phase;
  bit m_ba;
  bit m_bb;

  light_mode_controller #(.CH_W(8), .BLINK_CYC(4), .FADE_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .button(button),
    .light(light_a), .colour_idx(idx_a), .busy(busy_a)
  );

  light_mode_controller #(.CH_W(8), .BLINK_CYC(4), .FADE_STEP(16)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .button(button),
    .light(light_b), .colour_idx(idx_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fade(input int c, input int t, input int s);
    if (c < t) return (c + s >= t) ? t : c + s;
    if (c > t) return (c - s <= t) ? t : c - s;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int t[3];
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        m_la[c] = 0;
        m_lb[c] = 0;
      end
      m_idx = 0; m_bq = 0; m_cnt = 0; m_phase = 1; m_ba = 0; m_bb = 0;
    end else begin
      t[0] = (m_idx == 0 || m_idx == 1 || m_idx == 5) ? 255 : 0;
      t[1] = (m_idx >= 1 && m_idx <= 3) ? 255 : 0;
      t[2] = (m_idx >= 3 && m_idx <= 5) ? 255 : 0;
      m_ba = 0;
      m_bb = 0;
      for (int c = 0; c < 3; c++) begin
        case (mode)
          2'd0: begin m_la[c] = 255; m_lb[c] = 255; end
          2'd1: begin m_la[c] = t[c]; m_lb[c] = t[c]; end
          2'd2: begin m_la[c] = m_phase ? t[c] : 0; m_lb[c] = m_la[c]; end
          default: begin
            m_la[c] = fade(m_la[c], t[c], 1);
            m_lb[c] = fade(m_lb[c], t[c], 16);
            if (m_la[c] != t[c]) m_ba = 1;
            if (m_lb[c] != t[c]) m_bb = 1;
          end
        endcase
      end
      if (mode == 2'd2) begin
        if (m_cnt == 3) begin
          m_cnt = 0;
          m_phase = !m_phase;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
        m_phase = 1;
      end
      if (button && m_bq == 0) m_idx = (m_idx == 5) ? 0 : m_idx + 1;
      m_bq = button ? 1 : 0;
    end
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then compare after the edge.
  task automatic cycle(input logic r, input logic [1:0] m, input logic b);
    exp_t e;
    rst = r;
    mode = m;
    button = b;
    model_step();
    e.la  = {8'(m_la[0]), 8'(m_la[1]), 8'(m_la[2])};
    e.lb  = {8'(m_lb[0]), 8'(m_lb[1]), 8'(m_lb[2])};
    e.idx = 3'(m_idx);
    e.ba  = m_ba;
    e.bb  = m_bb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("light_a", 32'(light_a), 32'(e.la));
    check("light_b", 32'(light_b), 32'(e.lb));
    check("idx_a",   32'(idx_a),   32'(e.idx));
    check("idx_b",   32'(idx_b),   32'(e.idx));
    check("busy_a",  32'(busy_a),  32'(e.ba));
    check("busy_b",  32'(busy_b),  32'(e.bb));
  endtask

  initial begin
    logic [23:0] col[6];
    int          n;
    col[0] = 24'hFF0000; col[1] = 24'hFFFF00; col[2] = 24'h00FF00;
    col[3] = 24'h00FFFF; col[4] = 24'h0000FF; col[5] = 24'hFF00FF;
    rst = 1'b0;
    mode = 2'd1;
    button = 1'b0;
    #1;

    // Reset with button toggling, then release
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd1, 1'(i % 2));
      check("rst_light", 32'(light_a), 32'h0);
      check("rst_idx",   32'(idx_a),   32'h0);
      check("rst_busy",  32'(busy_a),  32'h0);
    end
    cycle(1'b1, 2'd1, 1'b0);
    check("release_light", 32'(light_a), 32'hFF0000);

    // Button stepping in static mode, one long press
    for (int p = 0; p < 7; p++) begin
      n = (p == 3) ? 10 : 1;
      for (int h = 0; h < n; h++) cycle(1'b1, 2'd1, 1'b1);
      check("step_idx", 32'(idx_a), 32'((p + 1) % 6));
      cycle(1'b1, 2'd1, 1'b0);
      check("step_light", 32'(light_a), 32'(col[(p + 1) % 6]));
      cycle(1'b1, 2'd1, 1'b0);
    end

    // White override from a fresh reset, two presses
    cycle(1'b0, 2'd0, 1'b0);
    cycle(1'b1, 2'd0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      cycle(1'b1, 2'd0, 1'b1);
      check("white_light", 32'(light_a), 32'hFFFFFF);
      cycle(1'b1, 2'd0, 1'b0);
    end
    check("white_idx", 32'(idx_a), 32'd2);

    // Blink on blue: 4 on / 4 off, restart on re-entry
    for (int p = 0; p < 2; p++) begin
      cycle(1'b1, 2'd0, 1'b1);
      cycle(1'b1, 2'd0, 1'b0);
    end
    check("blink_idx", 32'(idx_a), 32'd4);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 2'd2, 1'b0);
      check("blink_light", 32'(light_a), ((i / 4) % 2 == 0) ? 32'h0000FF : 32'h0);
    end
    cycle(1'b1, 2'd1, 1'b0);
    cycle(1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'd2, 1'b0);
      check("blink_restart", 32'(light_a), (i < 4) ? 32'h0000FF : 32'h0);
    end

    // Full-scale fade to red, step 1
    cycle(1'b0, 2'd3, 1'b0);
    for (int i = 1; i <= 255; i++) begin
      cycle(1'b1, 2'd3, 1'b0);
      check("fade_light", 32'(light_a), 32'(i) << 16);
      check("fade_busy",  32'(busy_a),  (i < 255) ? 32'd1 : 32'd0);
    end

    // Fast fade retargeted mid-way at R=0x80
    cycle(1'b0, 2'd3, 1'b0);
    for (int i = 0; i < 20 && m_lb[0] != 128; i++) cycle(1'b1, 2'd3, 1'b0);
    check("retarget_start", 32'(light_b), 32'h800000);
    cycle(1'b1, 2'd3, 1'b1);
    check("retarget_edge",  32'(light_b), 32'h900000);
    check("retarget_idx",   32'(idx_b),   32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 2'd3, 1'b0);
    check("retarget_final", 32'(light_b), 32'hFFFF00);
    check("retarget_busy",  32'(busy_b),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_mode_controller.md
# light_mode_controller

Parametrised successor to the white/RGB lights selector. It combines button-driven colour stepping, colour-to-RGB lookup and output selection in one registered block. It adds channel-width parametrisation, blink and linear-fade modes, and a fade-busy flag. It sits between the board button/mode switches and the LED driver.

## Interface

**Parameters**
- `CH_W`, default 8: bits per colour channel; `light` is 3*CH_W bits wide.
- `BLINK_CYC`, default 16: cycles per blink half-period; must be ≥1.
- `FADE_STEP`, default 1: per-cycle channel increment/decrement in fade mode; must be ≥1 and < 2^CH_W.

**Ports** (clock and reset first)
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `mode`, input, 2: 0 white, 1 static colour, 2 blink, 3 fade.
- `button`, input, 1: level input; each rising edge steps the colour index.
- `light`, output, 3*CH_W: `{R,G,B}`, with R in the MSBs; registered.
- `colour_idx`, output, 3: current colour index, 0..5; registered.
- `busy`, output, 1: fade in progress; registered.

## Operation

**Reset**
- Condition: `rst`=0 at a rising edge.
- Effect: `light`=0, `colour_idx`=0, `busy`=0, `button_q`=0, blink counter=0, blink phase=on.

**Button edge detection**
- `button_q` registers `button` every cycle.
- A rising edge is `button`=1 and `button_q`=0.
- On an edge, `colour_idx` increments at that same clock edge; 5 wraps to 0.
- A held button gives exactly one step. Values 6 and 7 are unreachable.

**Target lookup** (combinational from `colour_idx`; MAX = all ones, CH_W bits)

| idx | colour  | R   | G   | B   |
|-----|---------|-----|-----|-----|
| 0   | red     | MAX | 0   | 0   |
| 1   | yellow  | MAX | MAX | 0   |
| 2   | green   | 0   | MAX | 0   |
| 3   | cyan    | 0   | MAX | MAX |
| 4   | blue    | 0   | 0   | MAX |
| 5   | magenta | MAX | 0   | MAX |

**Next-light by mode**
- Mode 0: `light` <= all ones. `colour_idx` still steps on button edges.
- Mode 1: `light` <= target.
- Mode 2:
  - `light` <= phase ? target : 0.
  - The counter increments each cycle. At `BLINK_CYC`-1 the counter goes to 0 and the phase toggles.
  - Whenever mode≠2, the counter is held at 0 and the phase at on.
- Mode 3: each channel moves independently toward its target.
  - If the channel is below target: channel <= min(channel+`FADE_STEP`, target).
  - If above: channel <= max(channel−`FADE_STEP`, target).
  - If equal: hold.
  - Arithmetic is computed at CH_W+1 bits, so the result never wraps.
- `busy` <= (mode==3) && (next light ≠ target).

**Boundary conditions**
- Button edge mid-fade: the target switches to the new index. The fade continues from the current `light` value with no jump.
- Mode change mid-fade or mid-blink: the new mode's rule applies at the next edge. `busy` falls at that edge if mode≠3.
- Button edge and mode change in the same cycle: both take effect at that edge. Next-light uses the pre-edge `colour_idx`.
- Reset mid-operation: all state returns to reset values at that edge. Inputs seen during reset are ignored, including `button_q`, which is forced to 0.

## Timing

- Button-to-index latency: 0 cycles. `colour_idx` changes at the edge sampling the rising `button`.
- Index-to-light latency:
  - Modes 1 and 2: 1 cycle.
  - Mode 3: ceil(|Δchannel| / `FADE_STEP`) cycles for the largest channel difference.
- Full-scale fade (CH_W=8, `FADE_STEP`=1): 255 cycles. `busy` deasserts at the same edge the last channel reaches target.
- Blink period: 2*`BLINK_CYC` cycles, as `BLINK_CYC` on then `BLINK_CYC` off. The first on-phase starts at the first cycle in mode 2.
- No combinational paths from inputs to outputs.

## Test plan

Defaults apply (CH_W=8) unless a scenario overrides a parameter.

1. **Reset.** Hold `rst`=0 for 3 cycles with `mode`=1 and `button` toggling, then release. Required: `light`=0, `colour_idx`=0, `busy`=0 throughout reset; `light`=FF0000 one cycle after release.
2. **Button stepping.** `mode`=1; 7 separate button pulses, one of them held for 10 cycles. Required: `colour_idx` sequence 1,2,3,4,5,0,1 with one step per pulse; `light` follows FFFF00, 00FF00, 00FFFF, 0000FF, FF00FF, FF0000, FFFF00, each one cycle later.
3. **White override.** `mode`=0, press button twice. Required: `light`=FFFFFF constant; `colour_idx`=2.
4. **Blink.** `BLINK_CYC`=4, `colour_idx`=4, switch to `mode`=2. Required: `light`=0000FF for 4 cycles, then 000000 for 4 cycles, repeating. Leaving and re-entering mode 2 restarts with the on-phase.
5. **Fade.** `FADE_STEP`=1, start from reset, `mode`=3, idx 0. Required: R=01,02,…,FF over 255 cycles; `busy`=1 until the edge where R=FF.
6. **Fade retarget.** `FADE_STEP`=16; press the button while R=0x80 mid-fade. Required:
   - R continues to rise from 0x80, saturating at FF without wrapping.
   - G rises in steps of 16 from 00 toward FF, saturating at FF on the final step.
   - `busy` clears at the edge where both R and G have reached FF.
